mips_mc_control: RTL
====================

MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

Interface
REQ-001 SHALL have parameter none; opcodes and function codes SHALL come from the team's MIPS declarations package (opcode_t, funct_t).
REQ-002 clk  in  1  system clock, all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; forces state FETCH immediately.
REQ-004 op  in  6  instruction opcode from IR[31:26].
REQ-005 funct  in  6  function code from IR[5:0].
REQ-006 rt0  in  1  IR[16]; for OP_BLTGEZ, 1=BGEZ, 0=BLTZ.
REQ-007 zero  in  1  ALU result == 0.
REQ-008 neg  in  1  ALU result bit 31.
REQ-009 pcen  out  1  PC register write enable.
REQ-010 iord  out  1  memory address select: 0=PC, 1=ALUOut.
REQ-011 memwrite, irwrite, regwrite  out  1 each  memory write, IR load, register file write.
REQ-012 regdst  out  2  write-register select: 00=rt, 01=rd, 10=$31.
REQ-013 memtoreg  out  2  write-data select: 00=ALUOut, 01=MDR, 10=PC.
REQ-014 alusrca  out  1  0=PC, 1=A; alusrcb  out  2  00=B, 01=4, 10=SignImm, 11=SignImm<<2.
REQ-015 alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 011 xor, 100 nor, 111 slt.
REQ-016 pcsrc  out  2  00=ALUResult, 01=ALUOut, 10=jump target, 11=A (register).
REQ-017 state_o  out  4  current state encoding, debug only.

Function
REQ-018 SHALL be a Moore FSM except pcen, which is combinational from state, zero, neg, rt0, op.
REQ-019 States/encodings SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXE 6, ALUWB 7, IEXE 8, IWB 9, BRANCH 10, JUMP 11, JAL 12, JR 13.
REQ-020 FETCH: iord=0, irwrite=1, alusrca=0, alusrcb=01, add, pcsrc=00, pcen=1; next DECODE.
REQ-021 DECODE: alusrca=0, alusrcb=11, add (branch target into ALUOut); next by op: LW/SW->MEMADR, RTYPE with funct F_JR->JR, other RTYPE->RTEXE, ADDI/OR->IEXE, BEQ/BNE/BLTGEZ->BRANCH, J->JUMP, JAL->JAL; any other op->FETCH with no side effects.
REQ-022 MEMADR: alusrca=1, alusrcb=10, add; next MEMRD (LW) or MEMWR (SW).
REQ-023 MEMRD: iord=1; next MEMWB. MEMWB: regdst=00, memtoreg=01, regwrite=1; next FETCH.
REQ-024 MEMWR: iord=1, memwrite=1; next FETCH.
REQ-025 RTEXE: alusrca=1, alusrcb=00, alucontrol from funct (ADD 010, SUB 110, AND 000, OR 001, XOR 011, NOR 100, SLT 111); unknown funct SHALL produce 010 and proceed; next ALUWB.
REQ-026 ALUWB: regdst=01, memtoreg=00, regwrite=1; next FETCH.
REQ-027 IEXE: alusrca=1, alusrcb=10, alucontrol 010 for ADDI, 001 for OR; next IWB. IWB: regdst=00, memtoreg=00, regwrite=1; next FETCH.
REQ-028 BRANCH: alusrca=1, pcsrc=01; BEQ/BNE: alusrcb=00, sub, pcen=zero (BEQ) or ~zero (BNE); BLTGEZ: alusrcb=00 with B irrelevant, alucontrol 010 on A+0 is not permitted; SHALL use slt semantics via neg: pcen=neg (BLTZ) or ~neg (BGEZ), datapath supplies A-0 with alusrcb=00 and B forced 0 externally; next FETCH.
REQ-029 JUMP: pcsrc=10, pcen=1; next FETCH.
REQ-030 JAL: pcsrc=10, pcen=1, regdst=10, memtoreg=10, regwrite=1 (PC already PC+4); next FETCH.
REQ-031 JR: pcsrc=11, pcen=1; next FETCH.
REQ-032 In every state, outputs not listed SHALL be 0 (alucontrol 010, selects 00).
REQ-033 Latencies: LW 5 cycles; SW, R-type, ADDI, ORI 4; branches, J, JAL, JR 3; unknown op 2.
REQ-034 memwrite and regwrite SHALL never both be 1; regwrite SHALL be 1 for exactly one cycle per writing instruction.

Reset
REQ-035 While reset=1: state=FETCH, state_o=0; outputs SHALL equal FETCH values except pcen, irwrite, memwrite, regwrite forced 0.
REQ-036 Reset asserted mid-instruction SHALL abort it with no further write enables; first FETCH executes on the first rising edge after reset deasserts.

Verification
REQ-037 Reset then LW (op 35): states 0,1,2,3,4,0; regwrite=1 with memtoreg=01 only in state 4.
REQ-038 BEQ with zero=1 -> pcen=1 in BRANCH, pcsrc=01; repeat with zero=0 -> pcen=0.
REQ-039 BLTGEZ rt0=0 neg=1 -> pcen=1; rt0=1 neg=1 -> pcen=0.
REQ-040 RTYPE funct 42 -> alucontrol=111 in RTEXE, regdst=01 regwrite=1 in ALUWB; funct 8 -> JR, pcsrc=11.
REQ-041 JAL (op 3) -> in state 12 pcen=1, pcsrc=10, regdst=10, memtoreg=10, regwrite=1; op 63 -> DECODE->FETCH, no enables.
REQ-042 Assert reset during MEMWR (state 5) -> state_o=0 asynchronously, memwrite=0 same cycle.

Source files
------------

// File: rtl/mips_mc_control.sv
// Multicycle MIPS controller: Moore FSM with registered control outputs and a
// combinational PC write enable resolved from branch flags.
package mips_pkg;
  typedef enum logic [5:0] {
    OP_RTYPE  = 6'd0,
    OP_BLTGEZ = 6'd1,
    OP_J      = 6'd2,
    OP_JAL    = 6'd3,
    OP_BEQ    = 6'd4,
    OP_BNE    = 6'd5,
    OP_ADDI   = 6'd8,
    OP_ORI    = 6'd13,
    OP_LW     = 6'd35,
    OP_SW     = 6'd43
  } opcode_t;

  typedef enum logic [5:0] {
    F_JR  = 6'd8,
    F_ADD = 6'd32,
    F_SUB = 6'd34,
    F_AND = 6'd36,
    F_OR  = 6'd37,
    F_XOR = 6'd38,
    F_NOR = 6'd39,
    F_SLT = 6'd42
  } funct_t;
endpackage

module mips_mc_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       rt0,
  input  logic       zero,
  input  logic       neg,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic [1:0] pcsrc,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEXE  = 4'd6,  S_ALUWB = 4'd7,
    S_IEXE   = 4'd8,  S_IWB    = 4'd9,  S_BRANCH = 4'd10, S_JUMP  = 4'd11,
    S_JAL    = 4'd12, S_JR     = 4'd13
  } state_t;

  state_t     r_state, w_next;
  logic       r_iord, r_memwrite, r_irwrite, r_regwrite, r_alusrca;
  logic [1:0] r_regdst, r_memtoreg, r_alusrcb, r_pcsrc;
  logic [2:0] r_alucontrol;
  logic       w_iord, w_memwrite, w_irwrite, w_regwrite, w_alusrca;
  logic [1:0] w_regdst, w_memtoreg, w_alusrcb, w_pcsrc;
  logic [2:0] w_alucontrol;
  logic       w_pcen;

  function automatic logic [2:0] alu_from_funct(input logic [5:0] f);
    case (f)
      F_ADD:   return 3'b010;
      F_SUB:   return 3'b110;
      F_AND:   return 3'b000;
      F_OR:    return 3'b001;
      F_XOR:   return 3'b011;
      F_NOR:   return 3'b100;
      F_SLT:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:              w_next = S_MEMADR;
          OP_RTYPE:                  w_next = (funct == F_JR) ? S_JR : S_RTEXE;
          OP_ADDI, OP_ORI:           w_next = S_IEXE;
          OP_BEQ, OP_BNE, OP_BLTGEZ: w_next = S_BRANCH;
          OP_J:                      w_next = S_JUMP;
          OP_JAL:                    w_next = S_JAL;
          default:                   w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_MEMWB;
      S_RTEXE:  w_next = S_ALUWB;
      S_IEXE:   w_next = S_IWB;
      default:  w_next = S_FETCH;
    endcase
  end

  // Outputs are decoded for the state being entered so they register alongside it.
  always_comb begin
    w_iord = 1'b0;  w_memwrite = 1'b0;  w_irwrite = 1'b0;  w_regwrite = 1'b0;
    w_alusrca = 1'b0;  w_regdst = 2'b00;  w_memtoreg = 2'b00;
    w_alusrcb = 2'b00; w_pcsrc = 2'b00;   w_alucontrol = 3'b010;
    case (w_next)
      S_FETCH:  begin w_irwrite = 1'b1; w_alusrcb = 2'b01; end
      S_DECODE: w_alusrcb = 2'b11;
      S_MEMADR: begin w_alusrca = 1'b1; w_alusrcb = 2'b10; end
      S_MEMRD:  w_iord = 1'b1;
      S_MEMWB:  begin w_memtoreg = 2'b01; w_regwrite = 1'b1; end
      S_MEMWR:  begin w_iord = 1'b1; w_memwrite = 1'b1; end
      S_RTEXE:  begin w_alusrca = 1'b1; w_alucontrol = alu_from_funct(funct); end
      S_ALUWB:  begin w_regdst = 2'b01; w_regwrite = 1'b1; end
      S_IEXE: begin
        w_alusrca    = 1'b1;
        w_alusrcb    = 2'b10;
        w_alucontrol = (op == OP_ORI) ? 3'b001 : 3'b010;
      end
      S_IWB:    w_regwrite = 1'b1;
      S_BRANCH: begin w_alusrca = 1'b1; w_pcsrc = 2'b01; w_alucontrol = 3'b110; end
      S_JUMP:   w_pcsrc = 2'b10;
      S_JAL: begin
        w_pcsrc = 2'b10; w_regdst = 2'b10; w_memtoreg = 2'b10; w_regwrite = 1'b1;
      end
      S_JR:     w_pcsrc = 2'b11;
      default:  w_alucontrol = 3'b010;
    endcase
  end

  // Reset loads FETCH controls; irwrite is masked at the port while reset is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_iord       <= 1'b0;
      r_memwrite   <= 1'b0;
      r_irwrite    <= 1'b1;
      r_regwrite   <= 1'b0;
      r_alusrca    <= 1'b0;
      r_regdst     <= 2'b00;
      r_memtoreg   <= 2'b00;
      r_alusrcb    <= 2'b01;
      r_pcsrc      <= 2'b00;
      r_alucontrol <= 3'b010;
    end else begin
      r_state      <= w_next;
      r_iord       <= w_iord;
      r_memwrite   <= w_memwrite;
      r_irwrite    <= w_irwrite;
      r_regwrite   <= w_regwrite;
      r_alusrca    <= w_alusrca;
      r_regdst     <= w_regdst;
      r_memtoreg   <= w_memtoreg;
      r_alusrcb    <= w_alusrcb;
      r_pcsrc      <= w_pcsrc;
      r_alucontrol <= w_alucontrol;
    end
  end

  always_comb begin
    w_pcen = 1'b0;
    if (reset) begin
      w_pcen = 1'b0;
    end else begin
      case (r_state)
        S_FETCH, S_JUMP, S_JAL, S_JR: w_pcen = 1'b1;
        S_BRANCH: begin
          case (op)
            OP_BEQ:    w_pcen = zero;
            OP_BNE:    w_pcen = ~zero;
            OP_BLTGEZ: w_pcen = rt0 ? ~neg : neg;
            default:   w_pcen = 1'b0;
          endcase
        end
        default: w_pcen = 1'b0;
      endcase
    end
  end

  assign pcen       = w_pcen;
  assign iord       = r_iord;
  assign memwrite   = r_memwrite;
  assign irwrite    = r_irwrite & ~reset;
  assign regwrite   = r_regwrite;
  assign regdst     = r_regdst;
  assign memtoreg   = r_memtoreg;
  assign alusrca    = r_alusrca;
  assign alusrcb    = r_alusrcb;
  assign alucontrol = r_alucontrol;
  assign pcsrc      = r_pcsrc;
  assign state_o    = r_state;

endmodule
